// File: rtl/bft_pkg.sv
// Shared sizing helpers and packet field layout for the BFT leaf interfaces.
// Packet layout, MSB first: {valid, addr, port, payload}.
package bft_pkg;

    localparam int STALL_W = 16;

    function automatic int addr_w(input int num_leaves);
        return $clog2(num_leaves);
    endfunction

    function automatic int port_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    function automatic int p_sz(input int num_leaves, input int num_ports, input int payload_sz);
        return 1 + addr_w(num_leaves) + port_w(num_ports) + payload_sz;
    endfunction

    // Field offsets for the default 16-leaf, 4-port, 32-bit-payload build.
    localparam int DEF_PAYLOAD_SZ = 32;
    localparam int DEF_P_SZ       = p_sz(16, 4, DEF_PAYLOAD_SZ);
    localparam int VALID_BIT      = DEF_P_SZ - 1;
    localparam int ADDR_MSB       = DEF_P_SZ - 2;
    localparam int ADDR_LSB       = port_w(4) + DEF_PAYLOAD_SZ;
    localparam int PORT_MSB       = ADDR_LSB - 1;
    localparam int PORT_LSB       = DEF_PAYLOAD_SZ;

endpackage

// File: rtl/bft_sync_fifo.sv
// Single-clock FIFO, depth 2**ASIZE; rdata is the head entry, read from registered storage.
// No bypass: a write becomes visible one cycle later; pushes while full and pops while empty are ignored.
module bft_sync_fifo #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [DSIZE-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ASIZE;

    logic [ASIZE:0]   wr_ptr_q, wr_ptr_d;
    logic [ASIZE:0]   rd_ptr_q, rd_ptr_d;
    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [DSIZE-1:0] mem_d [DEPTH];
    logic             wr_en, rd_en;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ASIZE] != rd_ptr_q[ASIZE]) &&
                   (wr_ptr_q[ASIZE-1:0] == rd_ptr_q[ASIZE-1:0]);
    assign rdata = mem_q[rd_ptr_q[ASIZE-1:0]];

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[ASIZE-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        mem_q    <= mem_d;
    end

endmodule

// File: rtl/bft_leaf_mport.sv
// Multi-port BFT leaf: per-port egress FIFOs round-robin merged onto the bus; ingress delivered 1 cycle after accept.
// Egress backpressure via per-port tx_ready (FIFO not full); ingress has none, bus_o and status are registered.
module bft_leaf_mport
    import bft_pkg::*;
#(
    parameter  int NUM_LEAVES = 16,
    parameter  int NUM_PORTS  = 4,
    parameter  int PAYLOAD_SZ = 32,
    parameter  int ADDR       = 0,
    parameter  int FIFO_AW    = 2,
    localparam int ADDR_W     = addr_w(NUM_LEAVES),
    localparam int PORT_W     = port_w(NUM_PORTS),
    localparam int P_SZ       = p_sz(NUM_LEAVES, NUM_PORTS, PAYLOAD_SZ)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [P_SZ-1:0]                  bus_i,
    output logic [P_SZ-1:0]                  bus_o,
    input  logic [NUM_PORTS-1:0]             tx_valid,
    output logic [NUM_PORTS-1:0]             tx_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0]      tx_dest,
    input  logic [NUM_PORTS*PORT_W-1:0]      tx_dport,
    input  logic [NUM_PORTS*PAYLOAD_SZ-1:0]  tx_data,
    output logic                             rx_valid,
    output logic [PORT_W-1:0]                rx_port,
    output logic [PAYLOAD_SZ-1:0]            rx_data,
    output logic [STALL_W-1:0]               stall_cnt
);

    localparam int V_BIT  = P_SZ - 1;
    localparam int A_MSB  = P_SZ - 2;
    localparam int A_LSB  = PORT_W + PAYLOAD_SZ;
    localparam int PT_MSB = A_LSB - 1;
    localparam int PT_LSB = PAYLOAD_SZ;
    localparam logic [ADDR_W-1:0] MY_ADDR = ADDR_W'(ADDR);

    logic [NUM_PORTS-1:0] full, empty, push, pop;
    logic [P_SZ-1:0]      head [NUM_PORTS];
    logic                 accept, slot_free, pend;
    logic                 grant_vld;
    logic [PORT_W-1:0]    grant_idx, idx;

    logic [P_SZ-1:0]       bus_o_q, bus_o_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [PORT_W-1:0]     rx_port_q, rx_port_d;
    logic [PAYLOAD_SZ-1:0] rx_data_q, rx_data_d;
    logic [STALL_W-1:0]    stall_q, stall_d;
    logic [PORT_W-1:0]     rr_ptr_q, rr_ptr_d;

    assign accept    = bus_i[V_BIT] && (bus_i[A_MSB:A_LSB] == MY_ADDR);
    assign slot_free = !bus_i[V_BIT] || accept;
    assign pend      = |(~empty);
    assign tx_ready  = ~full & {NUM_PORTS{!reset}};
    assign push      = tx_valid & tx_ready;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        bft_sync_fifo #(
            .DSIZE (P_SZ),
            .ASIZE (FIFO_AW)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .wdata ({1'b1,
                     tx_dest[i*ADDR_W +: ADDR_W],
                     tx_dport[i*PORT_W +: PORT_W],
                     tx_data[i*PAYLOAD_SZ +: PAYLOAD_SZ]}),
            .pop   (pop[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .rdata (head[i])
        );
    end

    // Round-robin: first non-empty port at or after rr_ptr, only when the slot is ours.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = PORT_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (!grant_vld && !empty[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
        grant_vld = grant_vld && slot_free;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pop[i] = grant_vld && (grant_idx == PORT_W'(i));
        end
    end

    always_comb begin
        bus_o_d    = '0;
        rx_valid_d = accept;
        rx_port_d  = rx_port_q;
        rx_data_d  = rx_data_q;
        stall_d    = stall_q;
        rr_ptr_d   = rr_ptr_q;

        if (grant_vld) begin
            bus_o_d  = head[grant_idx];
            rr_ptr_d = PORT_W'((int'(grant_idx) + 1) % NUM_PORTS);
        end else if (!slot_free) begin
            bus_o_d = bus_i;
        end

        if (accept) begin
            rx_port_d = bus_i[PT_MSB:PT_LSB];
            rx_data_d = bus_i[PAYLOAD_SZ-1:0];
        end

        if (pend && !slot_free && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end

        if (reset) begin
            bus_o_d    = '0;
            rx_valid_d = 1'b0;
            rx_port_d  = '0;
            rx_data_d  = '0;
            stall_d    = '0;
            rr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        bus_o_q    <= bus_o_d;
        rx_valid_q <= rx_valid_d;
        rx_port_q  <= rx_port_d;
        rx_data_q  <= rx_data_d;
        stall_q    <= stall_d;
        rr_ptr_q   <= rr_ptr_d;
    end

    assign bus_o     = bus_o_q;
    assign rx_valid  = rx_valid_q;
    assign rx_port   = rx_port_q;
    assign rx_data   = rx_data_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_bft_leaf_mport.sv
// Directed bench for bft_leaf_mport (16 leaves, 4 ports, 32-bit payload, ADDR=3, depth 4).
// bus_o traffic is checked against a queue of expected packets filled as stimulus is driven.
module tb_bft_leaf_mport;

    localparam int P_SZ = 39;

    logic          clk = 1'b0;
    logic          reset;
    logic [38:0]   bus_i;
    logic [38:0]   bus_o;
    logic [3:0]    tx_valid;
    logic [3:0]    tx_ready;
    logic [15:0]   tx_dest;
    logic [7:0]    tx_dport;
    logic [127:0]  tx_data;
    logic          rx_valid;
    logic [1:0]    rx_port;
    logic [31:0]   rx_data;
    logic [15:0]   stall_cnt;

    int            n_cmp = 0;
    int            n_err = 0;
    logic          mon_en = 1'b0;
    logic [38:0]   exp_q [$];
    logic [15:0]   exp_stall;
    logic [38:0]   pk;
    logic [38:0]   bp_pk [4];

    always #5 clk = ~clk;

    bft_leaf_mport #(
        .NUM_LEAVES (16),
        .NUM_PORTS  (4),
        .PAYLOAD_SZ (32),
        .ADDR       (3),
        .FIFO_AW    (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_i     (bus_i),
        .bus_o     (bus_o),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_dest   (tx_dest),
        .tx_dport  (tx_dport),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_port   (rx_port),
        .rx_data   (rx_data),
        .stall_cnt (stall_cnt)
    );

    function automatic logic [38:0] mk(input logic [3:0] a, input logic [1:0] p, input logic [31:0] d);
        return {1'b1, a, p, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_tx(input int i, input logic [3:0] a, input logic [1:0] p, input logic [31:0] d);
        tx_dest[i*4 +: 4]   = a;
        tx_dport[i*2 +: 2]  = p;
        tx_data[i*32 +: 32] = d;
    endtask

    // Advance one cycle and sample 1 time unit after the edge; every valid bus_o word must be expected.
    task automatic tick();
        logic [38:0] e;
        @(posedge clk);
        #1;
        if (mon_en && bus_o[P_SZ-1] === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("bus_o_unexpected", bus_o, 39'h0);
            end else begin
                e = exp_q.pop_front();
                chk("bus_o_order", bus_o, e);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus_i     = '0;
        tx_valid  = 4'hF;
        tx_dest   = '0;
        tx_dport  = '0;
        tx_data   = '0;
        exp_stall = '0;

        // Reset with all requests high: nothing may be accepted.
        repeat (3) tick();
        chk("rst_tx_ready", tx_ready, 4'h0);
        chk("rst_bus_o", bus_o, 39'h0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_port", rx_port, 2'd0);
        chk("rst_rx_data", rx_data, 32'h0);
        chk("rst_stall", stall_cnt, 16'h0);
        tx_valid = 4'h0;
        reset    = 1'b0;
        #1;
        chk("rel_tx_ready", tx_ready, 4'hF);
        mon_en = 1'b1;
        tick();
        chk("rel_no_inject", bus_o, 39'h0);

        // Ingress for this leaf, then pass-through of foreign traffic.
        bus_i = mk(4'd3, 2'd2, 32'hA5);
        tick();
        chk("ing_rx_valid", rx_valid, 1'b1);
        chk("ing_rx_port", rx_port, 2'd2);
        chk("ing_rx_data", rx_data, 32'hA5);
        chk("ing_bus_o", bus_o, 39'h0);
        bus_i = mk(4'd5, 2'd1, 32'h1234_5678);
        exp_q.push_back(bus_i);
        tick();
        chk("pt_rx_valid", rx_valid, 1'b0);
        chk("pt_rx_hold", rx_data, 32'hA5);
        bus_i = '0;
        tick();
        chk("pt_seen", exp_q.size(), 0);

        // Round-robin over all four ports, then ports 1 and 3 only.
        for (int i = 0; i < 4; i++) begin
            set_tx(i, 4'(8 + i), 2'(i), 32'hC0 + i);
            exp_q.push_back(mk(4'(8 + i), 2'(i), 32'hC0 + i));
        end
        tx_valid = 4'hF;
        tick();
        tx_valid = 4'h0;
        chk("rr_no_bypass", bus_o[P_SZ-1], 1'b0);
        repeat (4) tick();
        chk("rr_all_drained", exp_q.size(), 0);
        set_tx(1, 4'd10, 2'd3, 32'hD1);
        set_tx(3, 4'd12, 2'd0, 32'hD3);
        exp_q.push_back(mk(4'd10, 2'd3, 32'hD1));
        exp_q.push_back(mk(4'd12, 2'd0, 32'hD3));
        tx_valid = 4'b1010;
        tick();
        tx_valid = 4'h0;
        repeat (2) tick();
        chk("rr_13_drained", exp_q.size(), 0);

        // Backpressure on port 0 while the bus is busy with foreign traffic.
        for (int n = 0; n < 5; n++) begin
            bus_i = mk(4'd9, 2'd0, 32'hF000_0000 + n);
            exp_q.push_back(bus_i);
            set_tx(0, 4'd6, 2'd1, 32'hB000_0000 + n);
            tx_valid = 4'b0001;
            #1;
            chk("bp_tx_ready", tx_ready[0], (n < 4));
            if (n < 4) bp_pk[n] = mk(4'd6, 2'd1, 32'hB000_0000 + n);
            if (n >= 1) exp_stall++;
            tick();
        end
        tx_valid = 4'h0;
        chk("bp_stall_push", stall_cnt, exp_stall);
        repeat (2) begin
            bus_i = mk(4'd9, 2'd2, 32'hEEEE);
            exp_q.push_back(bus_i);
            exp_stall++;
            tick();
        end
        chk("bp_stall_busy", stall_cnt, exp_stall);
        bus_i = '0;
        #1;
        chk("bp_still_full", tx_ready[0], 1'b0);
        for (int n = 0; n < 4; n++) exp_q.push_back(bp_pk[n]);
        tick();
        chk("bp_ready_after_pop", tx_ready[0], 1'b1);
        repeat (3) tick();
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_stall_idle", stall_cnt, exp_stall);

        // Accept and inject on the same edge.
        set_tx(1, 4'd7, 2'd2, 32'h5151);
        pk = mk(4'd7, 2'd2, 32'h5151);
        tx_valid = 4'b0010;
        tick();
        tx_valid = 4'h0;
        exp_q.push_back(pk);
        bus_i = mk(4'd3, 2'd3, 32'hBEEF);
        tick();
        chk("ai_rx_valid", rx_valid, 1'b1);
        chk("ai_rx_port", rx_port, 2'd3);
        chk("ai_rx_data", rx_data, 32'hBEEF);
        chk("ai_bus_o", bus_o, pk);
        bus_i = '0;

        // Stall counter saturation with port 2 blocked.
        set_tx(2, 4'd1, 2'd1, 32'h2222);
        pk = mk(4'd1, 2'd1, 32'h2222);
        tx_valid = 4'b0100;
        tick();
        tx_valid = 4'h0;
        mon_en   = 1'b0;
        for (int i = 1; i <= 70000; i++) begin
            bus_i = mk(4'd9, 2'd0, 32'(i));
            if (exp_stall != 16'hFFFF) exp_stall++;
            tick();
            if (i == 65528) chk("sat_before", stall_cnt, exp_stall);
        end
        chk("sat_model", stall_cnt, exp_stall);
        chk("sat_hold", stall_cnt, 16'hFFFF);
        bus_i = '0;
        exp_q.push_back(pk);
        mon_en = 1'b1;
        tick();
        chk("sat_drained", exp_q.size(), 0);

        // Reset mid-operation discards queued packets.
        set_tx(0, 4'd2, 2'd0, 32'h0A0A);
        set_tx(3, 4'd4, 2'd3, 32'h0B0B);
        tx_valid = 4'b1001;
        tick();
        tx_valid = 4'h0;
        reset    = 1'b1;
        tick();
        chk("rstmid_bus_o", bus_o, 39'h0);
        chk("rstmid_stall", stall_cnt, 16'h0);
        reset = 1'b0;
        repeat (3) tick();
        chk("rstmid_no_inject", bus_o, 39'h0);
        chk("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
